// File: rtl/pixel_frame_streamer_if.sv
// Bundles the host write port, frame control and the filter-facing pixel stream of pixel_frame_streamer.
// The master side drives the inputs. The slave side is the streamer.
interface pixel_frame_streamer_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic          loop;
  logic          fill_now;
  logic [7:0]    Dout;
  logic          data_valid;
  logic          busy;
  logic          frame_done;
  logic          wr_err;
  logic [1:0]    state;

  modport master (
    output wr_en, wr_addr, wr_data, start, loop, fill_now,
    input  Dout, data_valid, busy, frame_done, wr_err, state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, loop, fill_now,
    output Dout, data_valid, busy, frame_done, wr_err, state
  );
endinterface

// File: rtl/pixel_frame_streamer.sv
// Holds one N x M frame of 8-bit pixels and streams it in raster order into the sobel filter.
// Each frame is a one-cycle zero lead byte followed by N*M pixels, and is paced on the filter's fill_now.
module pixel_frame_streamer #(
  parameter int N  = 5,
  parameter int M  = 5,
  parameter int AW = 5
) (
  input logic clk,
  input logic rst_n,
  pixel_frame_streamer_if.slave px
);
  localparam int            DEPTH    = N * M;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] LEAD = 2'b10;
  localparam logic [1:0] SEND = 2'b11;

  logic [7:0]    mem [0:DEPTH-1];
  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] idx_reg, rd_addr;
  logic [7:0]    dout_reg;
  logic          dv_reg, busy_reg, done_reg, err_reg;
  logic          writable, wr_ok, wr_bad;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (px.start) state_next = WAIT;
      WAIT:    if (px.fill_now) state_next = LEAD;
      LEAD:    state_next = SEND;
      SEND:    if (idx_reg == LAST_IDX) state_next = px.loop ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign writable = (state_reg == IDLE) || (state_reg == WAIT);
  assign wr_ok    = px.wr_en && writable && (px.wr_addr <= LAST_IDX);
  assign wr_bad   = px.wr_en && !wr_ok;

  // The read runs one pixel ahead of Dout: LEAD fetches pixel 0, and each SEND cycle fetches the next pixel.
  assign rd_addr = (state_reg == LEAD) ? '0 : idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[px.wr_addr] <= px.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      dout_reg  <= 8'h00;
      dv_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      err_reg   <= wr_bad;
      done_reg  <= 1'b0;
      dout_reg  <= 8'h00;
      dv_reg    <= 1'b0;
      case (state_reg)
        WAIT: if (px.fill_now) dv_reg <= 1'b1;
        LEAD: begin
          dv_reg   <= 1'b1;
          dout_reg <= mem[rd_addr];
        end
        SEND: begin
          if (idx_reg == LAST_IDX) begin
            idx_reg  <= '0;
            done_reg <= 1'b1;
          end else begin
            dv_reg   <= 1'b1;
            dout_reg <= mem[rd_addr];
            idx_reg  <= rd_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign px.Dout       = dout_reg;
  assign px.data_valid = dv_reg;
  assign px.busy       = busy_reg;
  assign px.frame_done = done_reg;
  assign px.wr_err     = err_reg;
  assign px.state      = state_reg;
endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed self-checking bench for pixel_frame_streamer with N = M = 5 (a 25-pixel frame).
`timescale 1ns/1ps
module tb_pixel_frame_streamer;
  localparam int AW   = 5;
  localparam int NPIX = 25;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_LEAD = 2'b10;
  localparam logic [1:0] S_SEND = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;

  logic [7:0] cap [NPIX];
  int         cap_wait;
  bit         cap_lead, cap_gapless, cap_done;
  logic [1:0] cap_after;

  pixel_frame_streamer_if #(.AW(AW)) px();

  pixel_frame_streamer #(.N(5), .M(5), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .px   (px)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (px.frame_done === 1'b1) done_count++;

  task automatic write_pixel(input logic [AW-1:0] a, input logic [7:0] d);
    px.wr_en = 1'b1; px.wr_addr = a; px.wr_data = d;
    @(negedge clk);
    px.wr_en = 1'b0;
  endtask

  // Waits for the lead byte, then records 25 pixels and the cycle that follows them.
  // drop_fill lowers fill_now once LEAD is seen, which mimics the filter leaving its fill state.
  task automatic capture_burst(input int budget, input bit drop_fill);
    cap_lead = 1'b0;
    cap_wait = 0;
    while (!cap_lead && cap_wait < budget) begin
      @(negedge clk);
      px.wr_en = 1'b0;
      cap_wait++;
      if (px.state === S_LEAD && px.data_valid === 1'b1 && px.Dout === 8'h00) cap_lead = 1'b1;
    end
    if (drop_fill) px.fill_now = 1'b0;
    cap_gapless = 1'b1;
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clk);
      cap[k] = px.Dout;
      if (!(px.data_valid === 1'b1 && px.state === S_SEND)) cap_gapless = 1'b0;
    end
    @(negedge clk);
    cap_done  = (px.frame_done === 1'b1) && (px.data_valid === 1'b0) && (px.Dout === 8'h00);
    cap_after = px.state;
  endtask

  task automatic test_reset();
    checks++; if (px.state !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0h expected 0", px.state); end
    checks++; if (px.data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv: got %0b expected 0", px.data_valid); end
    checks++; if (px.Dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %0h expected 00", px.Dout); end
    checks++; if (px.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", px.busy); end
    checks++; if (px.frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", px.frame_done); end
    checks++; if (px.wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err: got %0b expected 0", px.wr_err); end
    $display("reset: state=%0h dv=%0b dout=%0h", px.state, px.data_valid, px.Dout);
  endtask

  task automatic test_basic_frame();
    px.fill_now = 1'b1; px.loop = 1'b0; px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    checks++; if (px.state !== S_WAIT || px.busy !== 1'b1 || px.data_valid !== 1'b0) begin
      failures++; $display("FAIL basic_wait: got state=%0h busy=%0b dv=%0b expected 1/1/0", px.state, px.busy, px.data_valid); end
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || cap_wait != 1) begin failures++; $display("FAIL basic_lead: got lead=%0b after %0d cycles expected 1 after 1", cap_lead, cap_wait); end
    checks++; if (!cap_gapless) begin failures++; $display("FAIL basic_gapless: got gap in data_valid/SEND expected none"); end
    for (int k = 0; k < NPIX; k++) begin
      checks++; if (cap[k] !== 8'(k + 1)) begin failures++; $display("FAIL basic_pix%0d: got %0h expected %0h", k, cap[k], 8'(k + 1)); end
    end
    checks++; if (!cap_done) begin failures++; $display("FAIL basic_done: got no frame_done/dv=0/Dout=00 cycle expected one"); end
    checks++; if (cap_after !== S_IDLE || px.busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got state=%0h busy=%0b expected 0/0", cap_after, px.busy); end
    @(negedge clk);
    checks++; if (px.frame_done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %0b expected 0", px.frame_done); end
    $display("basic frame: lead after %0d, pix0=%0h pix24=%0h", cap_wait, cap[0], cap[24]);
  endtask

  task automatic test_fill_wait();
    px.fill_now = 1'b0; px.loop = 1'b0; px.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      px.start = 1'b0;
      checks++; if (px.state !== S_WAIT || px.data_valid !== 1'b0) begin
        failures++; $display("FAIL fill_wait_c%0d: got state=%0h dv=%0b expected 1/0", c, px.state, px.data_valid); end
    end
    px.fill_now = 1'b1;
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || cap_wait != 1) begin failures++; $display("FAIL fill_lead: got lead=%0b after %0d expected 1 after 1", cap_lead, cap_wait); end
    checks++; if (cap[0] !== 8'h01 || cap[12] !== 8'h0D || cap[24] !== 8'h19 || !cap_gapless) begin
      failures++; $display("FAIL fill_burst: got %0h/%0h/%0h gapless=%0b expected 01/0d/19/1", cap[0], cap[12], cap[24], cap_gapless); end
    checks++; if (!cap_done || cap_after !== S_IDLE) begin failures++; $display("FAIL fill_done: got done=%0b state=%0h expected 1/0", cap_done, cap_after); end
    $display("fill wait: lead after %0d, pix12=%0h", cap_wait, cap[12]);
  endtask

  task automatic test_write_reject();
    int w;
    px.fill_now = 1'b1; px.loop = 1'b0; px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    w = 0;
    while (px.state !== S_SEND && w < 10) begin @(negedge clk); w++; end
    checks++; if (px.state !== S_SEND) begin failures++; $display("FAIL wr_reach_send: got state=%0h expected 3", px.state); end
    px.start = 1'b1;
    write_pixel(5'd3, 8'hAA);
    px.start = 1'b0;
    checks++; if (px.wr_err !== 1'b1) begin failures++; $display("FAIL wr_send_err: got %0b expected 1", px.wr_err); end
    @(negedge clk);
    checks++; if (px.wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_pulse: got %0b expected 0", px.wr_err); end
    w = 0;
    while (px.state !== S_IDLE && w < 40) begin @(negedge clk); w++; end
    @(negedge clk);
    checks++; if (px.state !== S_IDLE) begin failures++; $display("FAIL wr_start_not_queued: got state=%0h expected 0", px.state); end
    write_pixel(5'd25, 8'h55);
    checks++; if (px.wr_err !== 1'b1) begin failures++; $display("FAIL wr_addr25_err: got %0b expected 1", px.wr_err); end
    write_pixel(5'd24, 8'h19);
    checks++; if (px.wr_err !== 1'b0) begin failures++; $display("FAIL wr_addr24_ok: got %0b expected 0", px.wr_err); end
    px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    capture_burst(4, 1'b0);
    for (int k = 0; k < NPIX; k++) begin
      checks++; if (cap[k] !== 8'(k + 1)) begin failures++; $display("FAIL wr_keep_pix%0d: got %0h expected %0h", k, cap[k], 8'(k + 1)); end
    end
    $display("write reject: pix3=%0h pix24=%0h", cap[3], cap[24]);
  endtask

  task automatic test_wait_write_boundary();
    px.fill_now = 1'b0; px.loop = 1'b0; px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    checks++; if (px.state !== S_WAIT) begin failures++; $display("FAIL bnd_wait: got state=%0h expected 1", px.state); end
    px.fill_now = 1'b1; px.wr_en = 1'b1; px.wr_addr = 5'd0; px.wr_data = 8'h77;
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || cap_wait != 1) begin failures++; $display("FAIL bnd_lead: got lead=%0b after %0d expected 1 after 1", cap_lead, cap_wait); end
    checks++; if (cap[0] !== 8'h77) begin failures++; $display("FAIL bnd_pix0: got %0h expected 77", cap[0]); end
    checks++; if (cap[1] !== 8'h02) begin failures++; $display("FAIL bnd_pix1: got %0h expected 02", cap[1]); end
    write_pixel(5'd0, 8'h01);
    checks++; if (px.wr_err !== 1'b0) begin failures++; $display("FAIL bnd_restore: got wr_err=%0b expected 0", px.wr_err); end
    $display("wait/lead write: pix0=%0h", cap[0]);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_count;
    px.fill_now = 1'b1; px.loop = 1'b1; px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || !cap_gapless || !cap_done || cap_after !== S_WAIT) begin
      failures++; $display("FAIL b2b_f1: got lead=%0b gapless=%0b done=%0b state=%0h expected 1/1/1/1", cap_lead, cap_gapless, cap_done, cap_after); end
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || cap_wait != 1) begin failures++; $display("FAIL b2b_gap: got lead=%0b after %0d expected 1 after 1", cap_lead, cap_wait); end
    checks++; if (cap[0] !== 8'h01 || cap[24] !== 8'h19 || !cap_gapless || !cap_done) begin
      failures++; $display("FAIL b2b_f2: got %0h/%0h gapless=%0b done=%0b expected 01/19/1/1", cap[0], cap[24], cap_gapless, cap_done); end
    // Third frame: fill_now falls during SEND, as the filter starts storing, and must not disturb the burst.
    capture_burst(4, 1'b1);
    checks++; if (!cap_lead || !cap_gapless || cap[24] !== 8'h19 || cap_after !== S_WAIT) begin
      failures++; $display("FAIL b2b_f3: got lead=%0b gapless=%0b pix24=%0h state=%0h expected 1/1/19/1", cap_lead, cap_gapless, cap[24], cap_after); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (px.state !== S_WAIT || px.data_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_hold_c%0d: got state=%0h dv=%0b expected 1/0", c, px.state, px.data_valid); end
    end
    checks++; if (done_count - d0 != 3) begin failures++; $display("FAIL b2b_done3: got %0d pulses expected 3", done_count - d0); end
    px.loop = 1'b0; px.fill_now = 1'b1;
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || cap_wait != 1 || cap[12] !== 8'h0D || cap_after !== S_IDLE) begin
      failures++; $display("FAIL b2b_f4: got lead=%0b after %0d pix12=%0h state=%0h expected 1/1/0d/0", cap_lead, cap_wait, cap[12], cap_after); end
    @(negedge clk);
    checks++; if (done_count - d0 != 4) begin failures++; $display("FAIL b2b_done4: got %0d pulses expected 4", done_count - d0); end
    $display("back to back: %0d frame_done pulses", done_count - d0);
  endtask

  task automatic test_reset_mid();
    int w;
    px.fill_now = 1'b1; px.loop = 1'b0; px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    w = 0;
    while (!(px.state === S_SEND && px.Dout === 8'h0D) && w < 40) begin @(negedge clk); w++; end
    checks++; if (px.state !== S_SEND || px.Dout !== 8'h0D) begin failures++; $display("FAIL rst_reach_pix12: got state=%0h dout=%0h expected 3/0d", px.state, px.Dout); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (px.data_valid !== 1'b0 || px.Dout !== 8'h00) begin failures++; $display("FAIL rst_async_out: got dv=%0b dout=%0h expected 0/00", px.data_valid, px.Dout); end
    checks++; if (px.state !== S_IDLE || px.busy !== 1'b0) begin failures++; $display("FAIL rst_async_state: got state=%0h busy=%0b expected 0/0", px.state, px.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (px.state !== S_IDLE) begin failures++; $display("FAIL rst_release_idle: got %0h expected 0", px.state); end
    px.start = 1'b1;
    @(negedge clk);
    px.start = 1'b0;
    capture_burst(4, 1'b0);
    checks++; if (!cap_lead || !cap_gapless || !cap_done) begin failures++; $display("FAIL rst_resend: got lead=%0b gapless=%0b done=%0b expected 1/1/1", cap_lead, cap_gapless, cap_done); end
    for (int k = 0; k < NPIX; k++) begin
      checks++; if (cap[k] !== 8'(k + 1)) begin failures++; $display("FAIL rst_pix%0d: got %0h expected %0h", k, cap[k], 8'(k + 1)); end
    end
    $display("reset mid-frame: resend pix0=%0h pix12=%0h", cap[0], cap[12]);
  endtask

  initial begin
    px.wr_en = 1'b0; px.wr_addr = '0; px.wr_data = 8'h00;
    px.start = 1'b0; px.loop = 1'b0; px.fill_now = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NPIX; i++) write_pixel(AW'(i), 8'(i + 1));
    test_basic_frame();
    test_fill_wait();
    test_write_reject();
    test_wait_write_boundary();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_frame_streamer.md
Name: pixel_frame_streamer

Overview:
- Transmit side of the sobel filter pixel-input interface. Holds one N x M frame of 8-bit pixels, loaded through a host write port.
- On request, streams the frame in raster order to the filter's Din/data_valid inputs. Paces each frame on the filter's fill_now status so a new frame is never sent while the filter is in FIX/CONVOLUTE.
- Sits between the frame source (testbench/host) and the filter.

Parameters:
- N, 5, image rows
- M, 5, image columns
- AW, 5, pixel address width; must satisfy 2^AW >= N*M

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  host pixel write strobe
- wr_addr  input  AW  raster index of written pixel (row*M + col)
- wr_data  input  8  pixel value
- start  input  1  request one frame transmission (sampled each cycle)
- loop  input  1  when high at frame end, re-arm automatically for the next frame
- fill_now  input  1  from filter; 1 = filter ready to accept a frame
- Dout  output  8  pixel byte to filter Din
- data_valid  output  1  to filter data_valid
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse after the last pixel is driven
- wr_err  output  1  one-cycle pulse when a write is rejected
- state  output  2  current FSM state

Behaviour:
- Reset (rst_n low, async): state=IDLE, Dout=8'h00, data_valid=0, busy=0, frame_done=0, wr_err=0, pixel index=0. Frame memory contents are not reset.
- All outputs are registered. Every value is updated on the rising clk edge.
- FSM encoding: IDLE=2'b00, WAIT=2'b01, LEAD=2'b10, SEND=2'b11.
- IDLE: start=1 -> WAIT. Otherwise stay.
- WAIT: fill_now=1 -> LEAD. Otherwise stay, with data_valid=0.
- LEAD: exactly one cycle. data_valid=1, Dout=8'h00. This is the filter's IDLE->STORE trigger cycle; the filter does not capture this byte. Always -> SEND.
- SEND: exactly N*M consecutive cycles.
  - data_valid=1 and Dout=mem[idx], with idx running 0..N*M-1, one per cycle, no gaps. Pixel k is on Dout in the (k+1)-th cycle after LEAD.
  - fill_now is ignored in SEND.
  - After idx=N*M-1: frame_done pulses in the following cycle. Next state is WAIT if loop=1, otherwise IDLE. idx returns to 0.
  - data_valid=0 and Dout=8'h00 in the cycle after the last pixel.
- Writes:
  - Accepted in IDLE and WAIT only: mem[wr_addr] <= wr_data.
  - Writes in LEAD/SEND are discarded and pulse wr_err in the next cycle.
  - wr_addr >= N*M is discarded and pulses wr_err.
- Write/read same cycle (WAIT->LEAD boundary): the write completes before LEAD. The frame sent includes it.
- start while busy: ignored; start is not queued.
- loop deasserted mid-frame: the current frame completes, then -> IDLE.
- Reset mid-frame: outputs return to reset values immediately and data_valid drops asynchronously. The filter side recovers via its own reset.
- No arithmetic beyond an AW-bit index counter. The counter compares against N*M-1 and never wraps past N*M-1.

Test Plan:
- Load mem[i]=i+1 (i=0..24); start=1 with fill_now=1 -> WAIT 1 cycle, LEAD with Dout=00/data_valid=1, then Dout=01..19h on 25 consecutive cycles, frame_done one cycle after Dout=19h, state=00.
- Hold fill_now=0 for 10 cycles after start -> stays in WAIT (state=01, data_valid=0); fill_now=1 -> LEAD on next edge, then normal 25-pixel burst.
- wr_en during SEND at addr 3 data AAh -> wr_err pulse. Following frame still sends original 04h at pixel 3. Write addr 25 in IDLE -> wr_err, no memory change.
- loop=1, fill_now=1 continuously -> back-to-back frames separated by one WAIT cycle. Each frame is 1 LEAD + 25 SEND cycles and frame_done pulses once per frame.
- Connect to sobel_filter (N=M=5) with a constant pixel 10h -> filter captures all 25 pixels, enters FIX, produces 9 results of 0000h. The streamer waits in WAIT (loop=1) until fill_now returns to 1.
- rst_n low at SEND pixel 12 -> data_valid=0, Dout=00, state=00 without a clock edge. After release, start resends from pixel 0.
